irq_nest_ctrl: RTL and testbench

- Sits between the HETI interrupt controller's arbiter outputs and the core's interrupt interface.
- Holds a LIFO of active interrupt contexts and decides which interrupts may reach the core. A candidate must have a level above the current running level, and the running handler must be nestable.
- Presents a registered request to the core.
- On core acceptance, pushes the context and returns a one-cycle claim ack plus ID to the controller. On handler exit (mret), pops the context.

---
 rtl/hetic_pkg.sv | 38 +++
 rtl/irq_ctx_stack.sv | 58 +++++
 rtl/irq_nest_ctrl.sv | 147 ++++++++++++++
 tb/tb_irq_nest_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hetic_pkg.sv
// ----------------------------------------------------------------------------
// hetic_pkg : shared types and width helpers for the HETI nesting controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hetic_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned c_nr_irq_lines = 64;
  localparam int unsigned c_nr_irq_prios = 32;
  localparam int unsigned c_stack_depth  = 8;
  localparam int unsigned c_irq_width    = idx_width(c_nr_irq_lines);
  localparam int unsigned c_prio_width   = idx_width(c_nr_irq_prios);

  typedef struct packed {
    logic [c_irq_width-1:0]  id;
    logic [c_prio_width-1:0] level;
    logic                    heti;
    logic                    nest;
  } irq_ctx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CLAIM = 2'd2
  } nest_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_ctx_stack.sv
// ----------------------------------------------------------------------------
// irq_ctx_stack : LIFO of interrupt contexts; a simultaneous pop and push
//                 replaces the top entry. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_ctx_stack
  import hetic_pkg::*;
#(
  parameter  int unsigned StackDepth = c_stack_depth,
  localparam int unsigned DepthWidth = cnt_width(StackDepth),
  localparam int unsigned IdxWidth   = idx_width(StackDepth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  irq_ctx_t              push_ctx_i,
  input  logic                  pop_i,
  output irq_ctx_t              top_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  empty_o,
  output logic                  full_o
);

  irq_ctx_t              r_mem [StackDepth];
  logic [DepthWidth-1:0] r_depth;
  logic                  w_do_pop;
  logic                  w_do_push;
  logic [IdxWidth-1:0]   w_wr_idx;
  logic [IdxWidth-1:0]   w_top_idx;

  assign empty_o   = (r_depth == '0);
  assign full_o    = (r_depth == DepthWidth'(StackDepth));
  assign w_do_pop  = pop_i & ~empty_o;
  // A pop frees a slot, so a push on a full stack is fine in the same cycle.
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign w_wr_idx  = IdxWidth'(r_depth - DepthWidth'(w_do_pop));
  assign w_top_idx = IdxWidth'(r_depth - DepthWidth'(1));
  assign top_o     = empty_o ? '0 : r_mem[w_top_idx];
  assign depth_o   = r_depth;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_depth <= '0;
      for (int unsigned i = 0; i < StackDepth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[w_wr_idx] <= push_ctx_i;
      end
      r_depth <= r_depth + DepthWidth'(w_do_push) - DepthWidth'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_nest_ctrl.sv
// ----------------------------------------------------------------------------
// irq_nest_ctrl : gates HETI arbiter winners into the core by level and
//                 nestability, tracking active handlers on a context stack.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_nest_ctrl
  import hetic_pkg::*;
#(
  parameter  int unsigned NrIrqLines = c_nr_irq_lines,
  parameter  int unsigned NrIrqPrios = c_nr_irq_prios,
  parameter  int unsigned StackDepth = c_stack_depth,
  localparam int unsigned IrqWidth   = idx_width(NrIrqLines),
  localparam int unsigned PrioWidth  = idx_width(NrIrqPrios),
  localparam int unsigned DepthWidth = cnt_width(StackDepth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  hetic_valid_i,
  input  logic [IrqWidth-1:0]   hetic_id_i,
  input  logic [PrioWidth-1:0]  hetic_level_i,
  input  logic                  hetic_heti_i,
  input  logic                  hetic_nest_i,
  output logic                  hetic_ack_o,
  output logic [IrqWidth-1:0]   hetic_ack_id_o,
  output logic                  core_irq_req_o,
  output logic [IrqWidth-1:0]   core_irq_id_o,
  output logic [PrioWidth-1:0]  core_irq_level_o,
  output logic                  core_irq_heti_o,
  input  logic                  core_irq_ack_i,
  input  logic                  core_irq_exit_i,
  output logic [PrioWidth-1:0]  cur_level_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  exit_err_o,
  input  logic                  exit_err_clr_i
);

  nest_state_e   r_state;
  nest_state_e   w_state_nxt;
  irq_ctx_t      r_req_ctx;
  irq_ctx_t      w_in_ctx;
  irq_ctx_t      w_top;
  logic          r_req;
  logic          r_ack;
  logic [IrqWidth-1:0] r_ack_id;
  logic          r_exit_err;
  logic          w_empty;
  logic          w_full;
  logic          w_eligible;
  logic          w_new_ctx;
  logic          w_latch;
  logic          w_push;
  logic          w_unused;

  irq_ctx_stack #(
    .StackDepth (StackDepth)
  ) u_stack (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (w_push),
    .push_ctx_i (r_req_ctx),
    .pop_i      (core_irq_exit_i),
    .top_o      (w_top),
    .depth_o    (depth_o),
    .empty_o    (w_empty),
    .full_o     (w_full)
  );

  assign w_in_ctx = '{id: hetic_id_i, level: hetic_level_i,
                      heti: hetic_heti_i, nest: hetic_nest_i};

  // Empty stack reads as level 0, so thread level needs no special case.
  assign w_eligible = hetic_valid_i & (hetic_level_i > w_top.level)
                    & (w_empty | w_top.nest) & ~w_full;
  assign w_new_ctx  = (hetic_id_i != r_req_ctx.id)
                    | (hetic_level_i != r_req_ctx.level);
  assign w_unused   = ^{w_top.id, w_top.heti};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_eligible) w_state_nxt = REQ;
      REQ: begin
        if (core_irq_ack_i)   w_state_nxt = CLAIM;
        else if (!w_eligible) w_state_nxt = IDLE;
      end
      CLAIM:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_latch = 1'b0;
    w_push  = 1'b0;
    case (r_state)
      IDLE: w_latch = w_eligible;
      REQ: begin
        w_push  = core_irq_ack_i;
        w_latch = ~core_irq_ack_i & w_eligible & w_new_ctx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_req_ctx  <= '0;
      r_req      <= 1'b0;
      r_ack      <= 1'b0;
      r_ack_id   <= '0;
      r_exit_err <= 1'b0;
    end else begin
      if (w_latch) begin
        r_req_ctx <= w_in_ctx;
      end
      r_req    <= (w_state_nxt == REQ);
      r_ack    <= w_push;
      r_ack_id <= w_push ? r_req_ctx.id : '0;
      if (core_irq_exit_i && w_empty) begin
        r_exit_err <= 1'b1;
      end else if (exit_err_clr_i) begin
        r_exit_err <= 1'b0;
      end
    end
  end

  assign core_irq_req_o   = r_req;
  assign core_irq_id_o    = r_req_ctx.id;
  assign core_irq_level_o = r_req_ctx.level;
  assign core_irq_heti_o  = r_req_ctx.heti;
  assign hetic_ack_o      = r_ack;
  assign hetic_ack_id_o   = r_ack_id;
  assign cur_level_o      = w_top.level;
  assign exit_err_o       = r_exit_err;

endmodule

`default_nettype wire

// File: tb/tb_irq_nest_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_nest_ctrl : directed and randomized bench for irq_nest_ctrl against a
//                    queue-based reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_irq_nest_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       hetic_valid_i;
  logic [5:0] hetic_id_i;
  logic [4:0] hetic_level_i;
  logic       hetic_heti_i;
  logic       hetic_nest_i;
  logic       hetic_ack_o;
  logic [5:0] hetic_ack_id_o;
  logic       core_irq_req_o;
  logic [5:0] core_irq_id_o;
  logic [4:0] core_irq_level_o;
  logic       core_irq_heti_o;
  logic       core_irq_ack_i;
  logic       core_irq_exit_i;
  logic [4:0] cur_level_o;
  logic [3:0] depth_o;
  logic       exit_err_o;
  logic       exit_err_clr_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model: stack as queues, pending request as a flag plus fields
  int q_level[$];
  bit q_nest[$];
  bit m_req, m_cool, m_ack, m_err, m_heti, m_nest;
  int m_id, m_level, m_ack_id;

  irq_nest_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .hetic_valid_i   (hetic_valid_i),
    .hetic_id_i      (hetic_id_i),
    .hetic_level_i   (hetic_level_i),
    .hetic_heti_i    (hetic_heti_i),
    .hetic_nest_i    (hetic_nest_i),
    .hetic_ack_o     (hetic_ack_o),
    .hetic_ack_id_o  (hetic_ack_id_o),
    .core_irq_req_o  (core_irq_req_o),
    .core_irq_id_o   (core_irq_id_o),
    .core_irq_level_o(core_irq_level_o),
    .core_irq_heti_o (core_irq_heti_o),
    .core_irq_ack_i  (core_irq_ack_i),
    .core_irq_exit_i (core_irq_exit_i),
    .cur_level_o     (cur_level_o),
    .depth_o         (depth_o),
    .exit_err_o      (exit_err_o),
    .exit_err_clr_i  (exit_err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int cur;
    cur = (q_level.size() == 0) ? 0 : q_level[$];
    chk("req", 32'(core_irq_req_o), 32'(m_req));
    if (m_req) begin
      chk("req_id",    32'(core_irq_id_o),    32'(m_id));
      chk("req_level", 32'(core_irq_level_o), 32'(m_level));
      chk("req_heti",  32'(core_irq_heti_o),  32'(m_heti));
    end
    chk("ack", 32'(hetic_ack_o), 32'(m_ack));
    if (m_ack) chk("ack_id", 32'(hetic_ack_id_o), 32'(m_ack_id));
    chk("cur_level", 32'(cur_level_o), 32'(cur));
    chk("depth",     32'(depth_o),     32'(q_level.size()));
    chk("exit_err",  32'(exit_err_o),  32'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    hetic_valid_i = 0; hetic_id_i = 0; hetic_level_i = 0; hetic_heti_i = 0;
    hetic_nest_i = 0; core_irq_ack_i = 0; core_irq_exit_i = 0; exit_err_clr_i = 0;
    q_level.delete(); q_nest.delete();
    m_req = 0; m_cool = 0; m_ack = 0; m_err = 0;
    m_id = 0; m_level = 0; m_heti = 0; m_nest = 0; m_ack_id = 0;
    @(posedge clk); #1;
    chk("rst_req",    32'(core_irq_req_o),   0);
    chk("rst_id",     32'(core_irq_id_o),    0);
    chk("rst_level",  32'(core_irq_level_o), 0);
    chk("rst_heti",   32'(core_irq_heti_o),  0);
    chk("rst_ack",    32'(hetic_ack_o),      0);
    chk("rst_ack_id", 32'(hetic_ack_id_o),   0);
    chk("rst_cur",    32'(cur_level_o),      0);
    chk("rst_depth",  32'(depth_o),          0);
    chk("rst_err",    32'(exit_err_o),       0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // One clock: drive inputs, advance the model by the rules, compare outputs.
  task automatic step(input bit v, input int id, input int lvl, input bit heti,
                      input bit nest, input bit ack, input bit ex, input bit clr);
    bit elig;
    int cur, sz;
    @(negedge clk);
    hetic_valid_i = v; hetic_id_i = 6'(id); hetic_level_i = 5'(lvl);
    hetic_heti_i = heti; hetic_nest_i = nest;
    core_irq_ack_i = ack; core_irq_exit_i = ex; exit_err_clr_i = clr;

    sz   = q_level.size();
    cur  = (sz == 0) ? 0 : q_level[$];
    elig = v && (lvl > cur) && (sz == 0 || q_nest[$]) && (sz < 8);

    m_ack = m_req && ack;
    if (m_ack) m_ack_id = m_id;
    if (ex && sz == 0) m_err = 1;
    else if (clr) m_err = 0;
    if (ex && sz > 0) begin
      void'(q_level.pop_back());
      void'(q_nest.pop_back());
    end
    if (m_ack) begin
      q_level.push_back(m_level);
      q_nest.push_back(m_nest);
      m_req = 0;
      m_cool = 1;
    end else if (m_req) begin
      if (!elig) m_req = 0;
      else if (id != m_id || lvl != m_level) begin
        m_id = id; m_level = lvl; m_heti = heti; m_nest = nest;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (elig) begin
      m_req = 1; m_id = id; m_level = lvl; m_heti = heti; m_nest = nest;
    end

    @(posedge clk); #1;
    check_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_ctx(input int id, input int lvl, input bit nest);
    step(1, id, lvl, 0, nest, 0, 0, 0);
    step(1, id, lvl, 0, nest, 1, 0, 0);
    idle();
  endtask

  initial begin
    rst_ni = 1'b0;
    do_reset();

    // basic request / claim
    step(1, 5, 3, 1, 1, 0, 0, 0);
    chk("t1_req", 32'(core_irq_req_o), 1);
    chk("t1_id",  32'(core_irq_id_o),  5);
    chk("t1_lvl", 32'(core_irq_level_o), 3);
    step(1, 5, 3, 1, 1, 1, 0, 0);
    chk("t1_ack",    32'(hetic_ack_o),    1);
    chk("t1_ack_id", 32'(hetic_ack_id_o), 5);
    idle();
    chk("t1_cur",   32'(cur_level_o), 3);
    chk("t1_depth", 32'(depth_o),     1);
    chk("t1_ack_pulse", 32'(hetic_ack_o), 0);

    // nesting then unwinding
    push_ctx(9, 7, 1);
    chk("t2_depth", 32'(depth_o), 2);
    chk("t2_cur",   32'(cur_level_o), 7);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_cur_pop1", 32'(cur_level_o), 3);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_cur_pop2", 32'(cur_level_o), 0);
    chk("t2_depth0",   32'(depth_o), 0);

    // non-nestable handler blocks higher levels until it exits
    push_ctx(2, 3, 0);
    for (int i = 0; i < 20; i++) step(1, 4, 7, 0, 1, 0, 0, 0);
    chk("t3_blocked", 32'(core_irq_req_o), 0);
    step(1, 4, 7, 0, 1, 0, 1, 0);
    step(1, 4, 7, 0, 1, 0, 0, 0);
    chk("t3_req_after_exit", 32'(core_irq_req_o), 1);
    step(1, 4, 7, 0, 1, 1, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // late arrival replaces the latch; withdrawal retracts
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 5, 3, 0, 1, 0, 0, 0);
    step(1, 12, 6, 0, 1, 0, 0, 0);
    chk("t4_late_id", 32'(core_irq_id_o), 12);
    step(1, 12, 6, 0, 1, 1, 0, 0);
    chk("t4_ack_id", 32'(hetic_ack_id_o), 12);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 5, 3, 0, 1, 0, 0, 0);
    step(0, 5, 3, 0, 1, 0, 0, 0);
    chk("t4_retract", 32'(core_irq_req_o), 0);
    idle();
    chk("t4_no_ack", 32'(hetic_ack_o), 0);

    // full stack
    for (int i = 1; i <= 8; i++) push_ctx(i, i, 1);
    chk("t5_full", 32'(depth_o), 8);
    for (int i = 0; i < 3; i++) step(1, 20, 9, 0, 1, 0, 0, 0);
    chk("t5_no_req", 32'(core_irq_req_o), 0);
    step(1, 20, 9, 0, 1, 0, 1, 0);
    step(1, 20, 9, 0, 1, 0, 0, 0);
    chk("t5_req9", 32'(core_irq_level_o), 9);
    step(1, 20, 9, 0, 1, 1, 0, 0);
    idle();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, 0);

    // underflow flag and exit+ack together
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t6_err", 32'(exit_err_o), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_clr", 32'(exit_err_o), 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("t6_set_wins", 32'(exit_err_o), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    push_ctx(1, 1, 1);
    push_ctx(2, 2, 1);
    step(1, 7, 5, 0, 1, 0, 0, 0);
    step(1, 7, 5, 0, 1, 1, 1, 0);
    chk("t6_depth_same", 32'(depth_o), 2);
    chk("t6_top_new",    32'(cur_level_o), 5);

    // reset during handshake abandons the request
    step(1, 3, 9, 0, 1, 0, 0, 0);
    do_reset();
    idle();
    chk("t7_no_ack", 32'(hetic_ack_o), 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
